iir_biquad_tdm: RTL and testbench



---
 rtl/iir_pkg.sv | 48 ++++
 rtl/iir_coef_bank.sv | 63 ++++++
 rtl/iir_biquad_tdm.sv | 186 ++++++++++++++++++
 tb/tb_iir_biquad_tdm.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// Shared constants and helpers for the channel-interleaved AFE biquad.
// Holds coefficient addressing, the AFE default bank and a width-generic saturator.
package iir_pkg;

    localparam int N_COEF = 5;

    localparam logic [2:0] COEF_N1 = 3'd0;
    localparam logic [2:0] COEF_N2 = 3'd1;
    localparam logic [2:0] COEF_N3 = 3'd2;
    localparam logic [2:0] COEF_D1 = 3'd3;
    localparam logic [2:0] COEF_D2 = 3'd4;

    localparam int AFE_N1 = 32768;
    localparam int AFE_N2 = -63124;
    localparam int AFE_N3 = 30382;
    localparam int AFE_D1 = 61252;
    localparam int AFE_D2 = -28514;

    function automatic int afe_default(input int idx);
        case (idx)
            0:       afe_default = AFE_N1;
            1:       afe_default = AFE_N2;
            2:       afe_default = AFE_N3;
            3:       afe_default = AFE_D1;
            default: afe_default = AFE_D2;
        endcase
    endfunction

    // Clamp v to a w-bit signed range; ovf reports that clamping happened.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                      input int w,
                                                      output logic ovf);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo  = -hi - 64'sd1;
        ovf = 1'b0;
        sat_signed = v;
        if (v > hi) begin
            ovf        = 1'b1;
            sat_signed = hi;
        end else if (v < lo) begin
            ovf        = 1'b1;
            sat_signed = lo;
        end
    endfunction

endpackage

// File: rtl/iir_coef_bank.sv
// Shadow/active coefficient bank with a commit that lands on the next channel-0 sample.
// During the swap cycle the shadow values are forwarded so channel 0 already sees the new bank.
module iir_coef_bank
    import iir_pkg::*;
#(
    parameter int COEF_W = 18
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cfg_we,
    input  logic [2:0]               cfg_addr,
    input  logic signed [COEF_W-1:0] cfg_wdata,
    input  logic                     cfg_commit,
    input  logic                     cfg_clear,
    input  logic                     frame_start,
    output logic signed [COEF_W-1:0] coef [N_COEF],
    output logic                     swap,
    output logic                     clear,
    output logic                     cfg_pending
);

    logic signed [COEF_W-1:0] shadow [N_COEF];
    logic signed [COEF_W-1:0] active [N_COEF];
    logic                     clear_latch;

    assign swap  = cfg_pending && frame_start;
    assign clear = swap && clear_latch;

    always_comb begin
        for (int i = 0; i < N_COEF; i++) begin
            coef[i] = swap ? shadow[i] : active[i];
        end
    end

    // NOTE: these arrays are a handful of flops, not RAM, so resetting them in a loop is legitimate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_COEF; i++) begin
                shadow[i] <= COEF_W'(afe_default(i));
                active[i] <= COEF_W'(afe_default(i));
            end
            cfg_pending <= 1'b0;
            clear_latch <= 1'b0;
        end else begin
            if (swap) begin
                for (int i = 0; i < N_COEF; i++) begin
                    active[i] <= shadow[i];
                end
                cfg_pending <= 1'b0;
            end else if (cfg_commit) begin
                cfg_pending <= 1'b1;
                clear_latch <= cfg_clear;
            end
            // The write lands after the swap copy, so it waits for the next commit.
            for (int i = 0; i < N_COEF; i++) begin
                if (cfg_we && cfg_addr == 3'(i)) begin
                    shadow[i] <= cfg_wdata;
                end
            end
        end
    end

endmodule

// File: rtl/iir_biquad_tdm.sv
// Time-multiplexed direct-form-I biquad: one shared two-stage datapath, per-channel x/y history.
// Stage 1 reads history and forms products; stage 2 sums, saturates and writes history back.
module iir_biquad_tdm
    import iir_pkg::*;
#(
    parameter int N_CH      = 8,
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 18,
    parameter int COEF_FRAC = 15,
    parameter int GUARD     = 9,
    parameter int STATE_W   = DATA_W + GUARD,
    localparam int CH_W     = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    input  logic [CH_W-1:0]          in_ch,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     bypass,
    input  logic                     cfg_we,
    input  logic [2:0]               cfg_addr,
    input  logic signed [COEF_W-1:0] cfg_wdata,
    input  logic                     cfg_commit,
    input  logic                     cfg_clear,
    output logic                     cfg_pending,
    output logic                     out_valid,
    output logic [CH_W-1:0]          out_ch,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     sat_flag
);

    localparam int PROD_W = COEF_W + STATE_W;
    localparam int ACC_W  = PROD_W + 3;

    logic signed [COEF_W-1:0]  coef [N_COEF];
    logic                      swap;
    logic                      clear;
    logic                      in_ok;
    logic signed [STATE_W-1:0] xs;

    logic signed [STATE_W-1:0] x1_mem [N_CH];
    logic signed [STATE_W-1:0] x2_mem [N_CH];
    logic signed [STATE_W-1:0] y1_mem [N_CH];
    logic signed [STATE_W-1:0] y2_mem [N_CH];
    logic signed [STATE_W-1:0] x1_rd, x2_rd, y1_rd, y2_rd;

    logic                      s1_valid;
    logic [CH_W-1:0]           s1_ch;
    logic                      s1_byp;
    logic signed [STATE_W-1:0] s1_xs, s1_x1, s1_y1;
    logic signed [PROD_W-1:0]  s1_p [N_COEF];

    logic signed [ACC_W-1:0]   acc, y_full;
    logic signed [STATE_W-1:0] y_new, y_shift;
    logic signed [DATA_W-1:0]  o_new;
    logic                      ovf_y, ovf_o;

    assign in_ok = in_valid && (int'(in_ch) < N_CH);
    assign xs    = {in_data, {GUARD{1'b0}}};

    iir_coef_bank #(.COEF_W(COEF_W)) u_coef_bank (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_commit  (cfg_commit),
        .cfg_clear   (cfg_clear),
        .frame_start (in_valid && in_ch == '0),
        .coef        (coef),
        .swap        (swap),
        .clear       (clear),
        .cfg_pending (cfg_pending)
    );

    function automatic logic signed [PROD_W-1:0] mul(input logic signed [COEF_W-1:0] c,
                                                     input logic signed [STATE_W-1:0] v);
        return PROD_W'(c) * PROD_W'(v);
    endfunction

    // A clearing swap hands channel 0 an all-zero history in the same cycle the arrays are wiped.
    always_comb begin
        // NOTE: every output gets a default before the conditional, otherwise a latch is inferred.
        x1_rd = '0;
        x2_rd = '0;
        y1_rd = '0;
        y2_rd = '0;
        if (in_ok && !clear) begin
            x1_rd = x1_mem[in_ch];
            x2_rd = x2_mem[in_ch];
            y1_rd = y1_mem[in_ch];
            y2_rd = y2_mem[in_ch];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_ch    <= '0;
            s1_byp   <= 1'b0;
            s1_xs    <= '0;
            s1_x1    <= '0;
            s1_y1    <= '0;
            for (int i = 0; i < N_COEF; i++) s1_p[i] <= '0;
        end else begin
            s1_valid <= in_ok;
            if (in_ok) begin
                s1_ch            <= in_ch;
                s1_byp           <= bypass;
                s1_xs            <= xs;
                s1_x1            <= x1_rd;
                s1_y1            <= y1_rd;
                s1_p[COEF_N1]    <= mul(coef[COEF_N1], xs);
                s1_p[COEF_N2]    <= mul(coef[COEF_N2], x1_rd);
                s1_p[COEF_N3]    <= mul(coef[COEF_N3], x2_rd);
                s1_p[COEF_D1]    <= mul(coef[COEF_D1], y1_rd);
                s1_p[COEF_D2]    <= mul(coef[COEF_D2], y2_rd);
            end
        end
    end

    always_comb begin
        acc = ACC_W'(s1_p[COEF_N1]) + ACC_W'(s1_p[COEF_N2]) + ACC_W'(s1_p[COEF_N3])
            + ACC_W'(s1_p[COEF_D1]) + ACC_W'(s1_p[COEF_D2]);
        y_full  = acc >>> COEF_FRAC;
        ovf_y   = 1'b0;
        ovf_o   = 1'b0;
        y_new   = STATE_W'(sat_signed(64'(y_full), STATE_W, ovf_y));
        y_shift = y_new >>> GUARD;
        o_new   = DATA_W'(sat_signed(64'(y_shift), DATA_W, ovf_o));
        // Bypass still feeds history with y = xs so the filter restarts without a transient.
        if (s1_byp) begin
            y_new   = s1_xs;
            y_shift = s1_xs >>> GUARD;
            o_new   = DATA_W'(y_shift);
            ovf_y   = 1'b0;
            ovf_o   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_data  <= '0;
            sat_flag  <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_ch   <= s1_ch;
                out_data <= o_new;
            end
            if (swap) begin
                sat_flag <= 1'b0;
            end else if (s1_valid && (ovf_y || ovf_o)) begin
                sat_flag <= 1'b1;
            end
        end
    end

    // A clearing swap wins over the in-flight write-back of the previous channel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_CH; i++) begin
                x1_mem[i] <= '0;
                x2_mem[i] <= '0;
                y1_mem[i] <= '0;
                y2_mem[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < N_CH; i++) begin
                x1_mem[i] <= '0;
                x2_mem[i] <= '0;
                y1_mem[i] <= '0;
                y2_mem[i] <= '0;
            end
        end else if (s1_valid) begin
            x2_mem[s1_ch] <= s1_x1;
            x1_mem[s1_ch] <= s1_xs;
            y2_mem[s1_ch] <= s1_y1;
            y1_mem[s1_ch] <= y_new;
        end
    end

endmodule

// File: tb/tb_iir_biquad_tdm.sv
// Directed bench for iir_biquad_tdm: streams frames through the DUT and compares each output
// against a fixed-point reference of the recurrence, plus hand-computed spot values.
module tb_iir_biquad_tdm;

    localparam int N_CH   = 8;
    localparam int DATA_W = 16;
    localparam int COEF_W = 18;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic                     in_valid;
    logic [2:0]               in_ch;
    logic signed [DATA_W-1:0] in_data;
    logic                     bypass;
    logic                     cfg_we;
    logic [2:0]               cfg_addr;
    logic signed [COEF_W-1:0] cfg_wdata;
    logic                     cfg_commit;
    logic                     cfg_clear;
    logic                     cfg_pending;
    logic                     out_valid;
    logic [2:0]               out_ch;
    logic signed [DATA_W-1:0] out_data;
    logic                     sat_flag;

    always #5 clk = ~clk;

    iir_biquad_tdm #(.N_CH(N_CH), .DATA_W(DATA_W), .COEF_W(COEF_W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ch       (in_ch),
        .in_data     (in_data),
        .bypass      (bypass),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_commit  (cfg_commit),
        .cfg_clear   (cfg_clear),
        .cfg_pending (cfg_pending),
        .out_valid   (out_valid),
        .out_ch      (out_ch),
        .out_data    (out_data),
        .sat_flag    (sat_flag)
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        bit v;
        int ch;
        int data;
    } exp_t;

    exp_t   pipe [2];
    longint mx1 [N_CH];
    longint mx2 [N_CH];
    longint my1 [N_CH];
    longint my2 [N_CH];
    longint m_act [5];
    longint m_shd [5];
    bit     m_pending, m_clear, m_sat;

    function automatic longint clamp(input longint v, input int w, output bit s);
        longint hi = (64'sd1 <<< (w - 1)) - 1;
        longint lo = -hi - 1;
        s = 0;
        if (v > hi) begin s = 1; return hi; end
        if (v < lo) begin s = 1; return lo; end
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            mx1[i] = 0; mx2[i] = 0; my1[i] = 0; my2[i] = 0;
        end
        m_act = '{32768, -63124, 30382, 61252, -28514};
        m_shd = m_act;
        m_pending = 0; m_clear = 0; m_sat = 0;
        pipe[0] = '{0, 0, 0};
        pipe[1] = '{0, 0, 0};
    endtask

    task automatic model_step(input int ch, input int d, input bit byp, output int o);
        longint xs, acc, y;
        bit     s1, s2;
        xs = longint'(d) * 512;
        if (byp) begin
            y = xs;
            o = d;
        end else begin
            acc = m_act[0] * xs + m_act[1] * mx1[ch] + m_act[2] * mx2[ch]
                + m_act[3] * my1[ch] + m_act[4] * my2[ch];
            y = clamp(acc >>> 15, 25, s1);
            o = int'(clamp(y >>> 9, 16, s2));
            if (s1 || s2) m_sat = 1;
        end
        mx2[ch] = mx1[ch]; mx1[ch] = xs;
        my2[ch] = my1[ch]; my1[ch] = y;
    endtask

    // One clock: drive at the falling edge, advance the reference, compare the registered output.
    task automatic tick(input bit v, input int ch, input int d, input bit byp = 0,
                        input bit we = 0, input int addr = 0, input int wd = 0,
                        input bit commit = 0, input bit clr = 0);
        exp_t e;
        bit   swapped;
        int   o;
        @(negedge clk);
        in_valid   = v;
        in_ch      = 3'(ch);
        in_data    = 16'(d);
        bypass     = byp;
        cfg_we     = we;
        cfg_addr   = 3'(addr);
        cfg_wdata  = 18'(wd);
        cfg_commit = commit;
        cfg_clear  = clr;
        swapped = 0;
        e = '{0, 0, 0};
        if (v) begin
            if (ch == 0 && m_pending) begin
                m_act = m_shd;
                if (m_clear) begin
                    for (int i = 0; i < N_CH; i++) begin
                        mx1[i] = 0; mx2[i] = 0; my1[i] = 0; my2[i] = 0;
                    end
                end
                m_pending = 0;
                m_sat     = 0;
                swapped   = 1;
            end
            model_step(ch, d, byp, o);
            e = '{1, ch, o};
        end
        if (we && addr < 5) m_shd[addr] = wd;
        if (commit && !swapped) begin
            m_pending = 1;
            m_clear   = clr;
        end
        pipe[1] = pipe[0];
        pipe[0] = e;
        @(posedge clk);
        #1;
        n_vec++;
        if (out_valid !== pipe[1].v) begin
            n_bad++;
            $display("FAIL stream_valid: out_valid=%0b expected %0b at %0t", out_valid, pipe[1].v, $time);
        end else if (pipe[1].v && (int'(out_ch) !== pipe[1].ch || int'(out_data) !== pipe[1].data)) begin
            n_bad++;
            $display("FAIL stream_data: got ch=%0d data=%0d expected ch=%0d data=%0d at %0t",
                     out_ch, out_data, pipe[1].ch, pipe[1].data, $time);
        end
    endtask

    task automatic test_reset();
        reset_n = 0;
        in_valid = 0; in_ch = 0; in_data = 0; bypass = 0;
        cfg_we = 0; cfg_addr = 0; cfg_wdata = 0; cfg_commit = 0; cfg_clear = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || out_ch !== 3'd0 || out_data !== 16'sd0 ||
            sat_flag !== 1'b0 || cfg_pending !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: valid=%0b ch=%0d data=%0d sat=%0b pend=%0b expected all 0",
                     out_valid, out_ch, out_data, sat_flag, cfg_pending);
        end
        @(negedge clk);
        reset_n = 1;
    endtask

    task automatic test_impulse();
        int exp_v;
        for (int f = 0; f < 200; f++) begin
            for (int c = 0; c < N_CH; c++) begin
                tick(1, c, (f == 0 && c == 3) ? 1000 : 0);
                if (c == 4 && f < 2) begin
                    exp_v = (f == 0) ? 1000 : -58;
                    n_vec++;
                    if (out_ch !== 3'd3 || int'(out_data) !== exp_v) begin
                        n_bad++;
                        $display("FAIL impulse_hand_f%0d: got ch=%0d data=%0d expected ch=3 data=%0d",
                                 f, out_ch, out_data, exp_v);
                    end
                end
            end
        end
        repeat (2) tick(0, 0, 0);
    endtask

    task automatic test_step();
        for (int f = 0; f < 4000; f++) begin
            for (int c = 0; c < N_CH; c++) tick(1, c, 10000);
        end
        n_vec++;
        if (out_ch !== 3'd6 || int'(out_data) < 8655 || int'(out_data) > 8675) begin
            n_bad++;
            $display("FAIL step_dc_gain: got ch=%0d data=%0d expected ch=6 data near 8667", out_ch, out_data);
        end
        repeat (2) tick(0, 0, 0);
    endtask

    task automatic test_frame_commit();
        for (int c = 0; c < 5; c++) tick(1, c, 5000);
        tick(1, 5, 5000, 0, 1, 0, 16384);
        tick(1, 6, 5000, 0, 0, 0, 0, 1, 1);
        n_vec++;
        if (cfg_pending !== 1'b1) begin
            n_bad++;
            $display("FAIL commit_pending_set: cfg_pending=%0b expected 1", cfg_pending);
        end
        tick(1, 7, 5000);
        n_vec++;
        if (cfg_pending !== 1'b1) begin
            n_bad++;
            $display("FAIL commit_pending_hold: cfg_pending=%0b expected 1", cfg_pending);
        end
        tick(1, 0, 2000);
        n_vec++;
        if (cfg_pending !== 1'b0) begin
            n_bad++;
            $display("FAIL commit_pending_drop: cfg_pending=%0b expected 0", cfg_pending);
        end
        tick(1, 1, 0);
        n_vec++;
        if (out_ch !== 3'd0 || out_data !== 16'sd1000) begin
            n_bad++;
            $display("FAIL commit_new_n1: got ch=%0d data=%0d expected ch=0 data=1000", out_ch, out_data);
        end
        tick(1, 2, 4000);
        n_vec++;
        if (out_ch !== 3'd1 || out_data !== 16'sd0) begin
            n_bad++;
            $display("FAIL commit_cleared_hist: got ch=%0d data=%0d expected ch=1 data=0", out_ch, out_data);
        end
        tick(1, 3, 0);
        n_vec++;
        if (out_ch !== 3'd2 || out_data !== 16'sd2000) begin
            n_bad++;
            $display("FAIL commit_fresh_ch2: got ch=%0d data=%0d expected ch=2 data=2000", out_ch, out_data);
        end
        for (int c = 4; c < N_CH; c++) tick(1, c, 0);
        repeat (2) tick(0, 0, 0);
    endtask

    task automatic test_saturation();
        int afe [5] = '{32768, -63124, 30382, 61252, -28514};
        tick(0, 0, 0, 0, 1, 0, 131071);
        for (int a = 1; a < 5; a++) tick(0, 0, 0, 0, 1, a, 0);
        tick(0, 0, 0, 0, 0, 0, 0, 1, 1);
        for (int c = 0; c < N_CH; c++) begin
            tick(1, c, 32767);
            if (c == 1) begin
                n_vec++;
                if (out_ch !== 3'd0 || out_data !== 16'sd32767) begin
                    n_bad++;
                    $display("FAIL sat_out_clamp: got ch=%0d data=%0d expected ch=0 data=32767", out_ch, out_data);
                end
            end
        end
        repeat (2) tick(0, 0, 0);
        n_vec++;
        if (sat_flag !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_flag_set: sat_flag=%0b expected 1", sat_flag);
        end
        for (int a = 0; a < 5; a++) tick(0, 0, 0, 0, 1, a, afe[a]);
        tick(0, 0, 0, 0, 0, 0, 0, 1, 1);
        n_vec++;
        if (sat_flag !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_flag_sticky: sat_flag=%0b expected 1 before swap", sat_flag);
        end
        tick(1, 0, 0);
        n_vec++;
        if (sat_flag !== 1'b0 || cfg_pending !== 1'b0) begin
            n_bad++;
            $display("FAIL sat_flag_commit_clear: sat_flag=%0b pend=%0b expected 0 0", sat_flag, cfg_pending);
        end
        for (int c = 1; c < N_CH; c++) tick(1, c, 0);
        repeat (2) tick(0, 0, 0);
    endtask

    task automatic test_bypass();
        int ch = 0;
        bit v;
        for (int i = 0; i < 40; i++) begin
            v = ($urandom_range(0, 3) != 0);
            tick(v, ch, int'($urandom_range(0, 65535)) - 32768, 1);
            if (v) ch = (ch + 1) % N_CH;
        end
        tick(1, ch, -12345, 1);
        ch = (ch + 1) % N_CH;
        tick(0, 0, 0, 1);
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== -16'sd12345) begin
            n_bad++;
            $display("FAIL bypass_hand: got valid=%0b data=%0d expected 1 -12345", out_valid, out_data);
        end
        tick(0, 0, 0, 1);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL bypass_bubble: out_valid=%0b expected 0", out_valid);
        end
        for (int i = 0; i < 16; i++) begin
            tick(1, ch, int'($urandom_range(0, 2000)) - 1000, 0);
            ch = (ch + 1) % N_CH;
        end
        repeat (2) tick(0, 0, 0);
    endtask

    task automatic test_async_reset();
        tick(0, 0, 0, 0, 1, 0, 5);
        tick(0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick(1, 1, 3000);
        tick(1, 2, 3000);
        #2;
        reset_n  = 0;
        in_valid = 0;
        cfg_we   = 0;
        cfg_commit = 0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 16'sd0 || cfg_pending !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: valid=%0b data=%0d pend=%0b expected 0 0 0",
                     out_valid, out_data, cfg_pending);
        end
        repeat (2) @(negedge clk);
        reset_n = 1;
        model_reset();
        test_impulse();
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_step();
        test_frame_commit();
        test_saturation();
        test_bypass();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
